// File: rtl/gpio_pkg.sv
`default_nettype none
// ============================================================================
// Module   : gpio_pkg
// Brief    : Shared types and constants for the parametrised GPIO controller.
// Revision : 1.0 - initial release
// ============================================================================
package gpio_pkg;

  localparam int GPIO_MAX_PINS = 32;

  localparam logic [GPIO_MAX_PINS-1:0] GPIO_RST_REG   = '0;
  localparam logic [31:0]              GPIO_RST_RDATA = '0;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] w_data;
    logic        w_en;
    logic        req;
  } type_dbus2peri_s;

  typedef struct packed {
    logic [31:0] r_data;
    logic        ack;
  } type_peri2dbus_s;

  typedef enum logic [7:0] {
    GPIO_DOUT  = 8'h00,
    GPIO_DSET  = 8'h04,
    GPIO_DCLR  = 8'h08,
    GPIO_DIN   = 8'h0C,
    GPIO_DIR   = 8'h10,
    GPIO_IE    = 8'h14,
    GPIO_IP    = 8'h18,
    GPIO_ITYPE = 8'h1C,
    GPIO_IPOL  = 8'h20,
    GPIO_IBOTH = 8'h24,
    GPIO_DBEN  = 8'h28
  } type_gpio_ctrl_regs_e;

endpackage
`default_nettype wire

// File: rtl/gpio_in_cond.sv
`default_nettype none
// ============================================================================
// Module   : gpio_in_cond
// Brief    : Per-pin input conditioning: synchroniser, optional debouncer
//            (GPIO_DEBOUNCE_EN), previous-value flop and edge outputs.
// Revision : 1.0 - initial release
// ============================================================================
module gpio_in_cond #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pad_i,
  input  logic dben_i,
  output logic din_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_sync;
  logic                   w_din;
  logic                   r_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], pad_i};
    end
  end

  assign w_sync = r_sync[SYNC_STAGES-1];

`ifdef GPIO_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_db;

  // The filtered value tracks the synchroniser while bypassed so that
  // enabling the debouncer never produces a spurious transition.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_db  <= 1'b0;
    end else if (!dben_i) begin
      r_cnt <= '0;
      r_db  <= w_sync;
    end else if (w_sync == r_db) begin
      r_cnt <= '0;
    end else if (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
      r_cnt <= '0;
      r_db  <= w_sync;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign w_din = dben_i ? r_db : w_sync;
`else
  logic w_unused_cfg;
  assign w_unused_cfg = dben_i ^ (DEBOUNCE_CYCLES > 0);
  assign w_din        = w_sync;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev <= 1'b0;
    end else begin
      r_prev <= w_din;
    end
  end

  assign din_o  = w_din;
  assign rise_o = w_din & ~r_prev;
  assign fall_o = ~w_din & r_prev;

endmodule
`default_nettype wire

// File: rtl/gpio_ctrl_param.sv
`default_nettype none
// ============================================================================
// Module   : gpio_ctrl_param
// Brief    : Parametrised GPIO controller with split pads, atomic set/clear
//            and per-pin interrupts; GPIO_DEBOUNCE_EN adds input debouncing.
// Revision : 1.0 - initial release
// ============================================================================
module gpio_ctrl_param
  import gpio_pkg::*;
#(
  parameter int NUM_PINS        = 8,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                gpio_sel_i,
  input  type_dbus2peri_s     dbus2gpio_i,
  output type_peri2dbus_s     gpio2dbus_o,
  input  logic [NUM_PINS-1:0] gpio_in_i,
  output logic [NUM_PINS-1:0] gpio_out_o,
  output logic [NUM_PINS-1:0] gpio_oe_o,
  output logic                irq_o
);

  logic [NUM_PINS-1:0] r_dout, r_dir, r_ie, r_ip, r_itype, r_ipol, r_iboth;
  logic [NUM_PINS-1:0] w_dben, w_din, w_rise, w_fall, w_set, w_clr, w_wdata;
  logic                r_ack;
  logic [31:0]         r_rdata, w_rdata;
  logic                w_txn, w_wr;
  type_gpio_ctrl_regs_e w_addr;
  logic                w_unused_bus;

  for (genvar g = 0; g < NUM_PINS; g++) begin : g_pin
    gpio_in_cond #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_in_cond (
      .clk   (clk),
      .rst_n (rst_n),
      .pad_i (gpio_in_i[g]),
      .dben_i(w_dben[g]),
      .din_o (w_din[g]),
      .rise_o(w_rise[g]),
      .fall_o(w_fall[g])
    );
  end

  // A request still held during the ack cycle is blocked by r_ack.
  assign w_txn   = dbus2gpio_i.req & gpio_sel_i & ~r_ack;
  assign w_wr    = w_txn & dbus2gpio_i.w_en;
  assign w_addr  = type_gpio_ctrl_regs_e'(dbus2gpio_i.addr[7:0]);
  assign w_wdata = dbus2gpio_i.w_data[NUM_PINS-1:0];
  assign w_unused_bus = ^{dbus2gpio_i.addr[31:8], dbus2gpio_i.w_data};

  assign w_set = (r_itype & ((r_iboth & (w_rise | w_fall)) |
                             (~r_iboth & ((r_ipol & w_rise) | (~r_ipol & w_fall))))) |
                 (~r_itype & ~(w_din ^ r_ipol));
  assign w_clr = (w_wr && w_addr == GPIO_IP) ? w_wdata : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ack   <= 1'b0;
      r_rdata <= GPIO_RST_RDATA;
      r_dout  <= GPIO_RST_REG[NUM_PINS-1:0];
      r_dir   <= GPIO_RST_REG[NUM_PINS-1:0];
      r_ie    <= GPIO_RST_REG[NUM_PINS-1:0];
      r_ip    <= GPIO_RST_REG[NUM_PINS-1:0];
      r_itype <= GPIO_RST_REG[NUM_PINS-1:0];
      r_ipol  <= GPIO_RST_REG[NUM_PINS-1:0];
      r_iboth <= GPIO_RST_REG[NUM_PINS-1:0];
    end else begin
      r_ack   <= w_txn;
      r_rdata <= (w_txn && !dbus2gpio_i.w_en) ? w_rdata : GPIO_RST_RDATA;
      // Set events take priority over a simultaneous write-1-to-clear.
      r_ip    <= (r_ip & ~w_clr) | w_set;
      if (w_wr) begin
        case (w_addr)
          GPIO_DOUT:  r_dout  <= w_wdata;
          GPIO_DSET:  r_dout  <= r_dout | w_wdata;
          GPIO_DCLR:  r_dout  <= r_dout & ~w_wdata;
          GPIO_DIR:   r_dir   <= w_wdata;
          GPIO_IE:    r_ie    <= w_wdata;
          GPIO_ITYPE: r_itype <= w_wdata;
          GPIO_IPOL:  r_ipol  <= w_wdata;
          GPIO_IBOTH: r_iboth <= w_wdata;
          default: ;
        endcase
      end
    end
  end

`ifdef GPIO_DEBOUNCE_EN
  logic [NUM_PINS-1:0] r_dben;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dben <= GPIO_RST_REG[NUM_PINS-1:0];
    end else if (w_wr && w_addr == GPIO_DBEN) begin
      r_dben <= w_wdata;
    end
  end

  assign w_dben = r_dben;
`else
  assign w_dben = '0;
`endif

  always_comb begin
    w_rdata = '0;
    case (w_addr)
      GPIO_DOUT:  w_rdata = 32'(r_dout);
      GPIO_DIN:   w_rdata = 32'(w_din);
      GPIO_DIR:   w_rdata = 32'(r_dir);
      GPIO_IE:    w_rdata = 32'(r_ie);
      GPIO_IP:    w_rdata = 32'(r_ip);
      GPIO_ITYPE: w_rdata = 32'(r_itype);
      GPIO_IPOL:  w_rdata = 32'(r_ipol);
      GPIO_IBOTH: w_rdata = 32'(r_iboth);
`ifdef GPIO_DEBOUNCE_EN
      GPIO_DBEN:  w_rdata = 32'(w_dben);
`endif
      default:    w_rdata = '0;
    endcase
  end

  assign gpio2dbus_o.r_data = r_rdata;
  assign gpio2dbus_o.ack    = r_ack;
  assign gpio_out_o         = r_dout;
  assign gpio_oe_o          = r_dir;
  assign irq_o              = |(r_ip & r_ie);

endmodule
`default_nettype wire

// File: tb/tb_gpio_ctrl_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_gpio_ctrl_param
// Brief    : Self-checking bench for gpio_ctrl_param against a cycle-level
//            behavioural model (GPIO_DEBOUNCE_EN enables the debounce steps).
// Revision : 1.0 - initial release
// ============================================================================
module tb_gpio_ctrl_param;
  import gpio_pkg::*;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            sel;
  type_dbus2peri_s breq;
  type_peri2dbus_s bresp;
  logic [7:0]      pad, gout, goe;
  logic            irq;

  int checks = 0;
  int errors = 0;

  // Model state: registers, ack flag and the last three sampled pad values.
  logic [7:0] m_dout, m_dir, m_ie, m_ip, m_itype, m_ipol, m_iboth;
  logic       m_ack;
  logic [7:0] ph0, ph1, ph2;
  logic [31:0] rd;

  always #5 clk = ~clk;

  gpio_ctrl_param #(.NUM_PINS(8), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .gpio_sel_i (sel),
    .dbus2gpio_i(breq),
    .gpio2dbus_o(bresp),
    .gpio_in_i  (pad),
    .gpio_out_o (gout),
    .gpio_oe_o  (goe),
    .irq_o      (irq)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    {m_dout, m_dir, m_ie, m_ip, m_itype, m_ipol, m_iboth} = '0;
    m_ack = 1'b0;
    {ph0, ph1, ph2} = '0;
  endtask

  // DIN seen by software is the pad sampled two edges back.
  function automatic logic [31:0] model_read(input logic [7:0] a);
    case (a)
      8'h00: return {24'h0, m_dout};
      8'h0C: return {24'h0, ph1};
      8'h10: return {24'h0, m_dir};
      8'h14: return {24'h0, m_ie};
      8'h18: return {24'h0, m_ip};
      8'h1C: return {24'h0, m_itype};
      8'h20: return {24'h0, m_ipol};
      8'h24: return {24'h0, m_iboth};
      default: return 32'h0;
    endcase
  endfunction

  task automatic tick();
    logic txn, wr;
    logic [7:0] a, d, set, clr, p;
    txn = breq.req && sel && !m_ack;
    wr  = txn && breq.w_en;
    a   = breq.addr[7:0];
    d   = breq.w_data[7:0];
    p   = pad;
    for (int i = 0; i < 8; i++) begin
      if (m_itype[i]) begin
        if (m_iboth[i])     set[i] = ph1[i] != ph2[i];
        else if (m_ipol[i]) set[i] = ph1[i] && !ph2[i];
        else                set[i] = !ph1[i] && ph2[i];
      end else begin
        set[i] = ph1[i] == m_ipol[i];
      end
    end
    clr = (wr && a == 8'h18) ? d : 8'h00;
    @(posedge clk);
    #1;
    m_ip = (m_ip & ~clr) | set;
    if (wr) begin
      case (a)
        8'h00: m_dout  = d;
        8'h04: m_dout  = m_dout | d;
        8'h08: m_dout  = m_dout & ~d;
        8'h10: m_dir   = d;
        8'h14: m_ie    = d;
        8'h1C: m_itype = d;
        8'h20: m_ipol  = d;
        8'h24: m_iboth = d;
        default: ;
      endcase
    end
    m_ack = txn;
    ph2 = ph1; ph1 = ph0; ph0 = p;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic bus_x(input logic [7:0] a, input logic we, input logic [31:0] d,
                       input logic [31:0] exp, input string tag, output logic [31:0] r);
    breq.addr = {24'h0, a}; breq.w_data = d; breq.w_en = we; breq.req = 1'b1; sel = 1'b1;
    tick();
    r = bresp.r_data;
    chk({tag, "_ack"}, {31'h0, bresp.ack}, 32'h1);
    chk({tag, "_rdata"}, bresp.r_data, exp);
    breq.req = 1'b0; breq.w_en = 1'b0;
    tick();
    chk({tag, "_ack_drop"}, {31'h0, bresp.ack}, 32'h0);
  endtask

  task automatic bus(input logic [7:0] a, input logic we, input logic [31:0] d,
                     input string tag, output logic [31:0] r);
    bus_x(a, we, d, we ? 32'h0 : model_read(a), tag, r);
  endtask

  initial begin
    logic [7:0] addrs [14] = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18,
                               8'h1C, 8'h20, 8'h24, 8'h28, 8'h2C, 8'h3C, 8'hFC};
    rst_n = 1'b0; sel = 1'b0; pad = 8'h00; breq = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out", {24'h0, gout}, 32'h0);
    chk("rst_oe", {24'h0, goe}, 32'h0);
    chk("rst_irq", {31'h0, irq}, 32'h0);
    chk("rst_ack", {31'h0, bresp.ack}, 32'h0);
    chk("rst_rdata", bresp.r_data, 32'h0);
    rst_n = 1'b1;
    for (int i = 0; i < 14; i++) bus(addrs[i], 1'b0, 32'h0, $sformatf("rst_rd%0h", addrs[i]), rd);

    // Output path and atomic set/clear.
    bus(8'h10, 1'b1, 32'hFF, "wr_dir", rd);
    bus(8'h00, 1'b1, 32'hA5, "wr_dout", rd);
    chk("dout_a5", {24'h0, gout}, 32'hA5);
    chk("oe_ff", {24'h0, goe}, 32'hFF);
    bus(8'h04, 1'b1, 32'h0A, "dset", rd);
    chk("dset_af", {24'h0, gout}, 32'hAF);
    bus(8'h08, 1'b1, 32'h81, "dclr", rd);
    chk("dclr_2e", {24'h0, gout}, 32'h2E);
    pad = gout;
    ticks(3);
    bus(8'h0C, 1'b0, 32'h0, "din_loop", rd);
    chk("din_2e", rd, 32'h2E);

    // Held request: served, blocked during ack, served again.
    breq.addr = 32'h0; breq.req = 1'b1; breq.w_en = 1'b0; sel = 1'b1;
    tick(); chk("hold_ack1", {31'h0, bresp.ack}, 32'h1);
    tick(); chk("hold_ack2", {31'h0, bresp.ack}, 32'h0);
    tick(); chk("hold_ack3", {31'h0, bresp.ack}, 32'h1);
    breq.req = 1'b0;
    tick(); chk("hold_ack4", {31'h0, bresp.ack}, 32'h0);

    // Edge interrupt on pin0.
    pad = 8'h00;
    ticks(4);
    bus(8'h1C, 1'b1, 32'h01, "e_itype", rd);
    bus(8'h20, 1'b1, 32'h01, "e_ipol", rd);
    bus(8'h18, 1'b1, 32'hFF, "e_clr0", rd);
    bus(8'h14, 1'b1, 32'h01, "e_ie", rd);
    chk("e_irq_idle", {31'h0, irq}, 32'h0);
    pad = 8'h01;
    tick(); chk("e_irq_c1", {31'h0, irq}, 32'h0);
    tick(); chk("e_irq_c2", {31'h0, irq}, 32'h0);
    tick(); chk("e_irq_c3", {31'h0, irq}, 32'h1);
    bus(8'h18, 1'b1, 32'h01, "e_w1c", rd);
    chk("e_irq_clr", {31'h0, irq}, 32'h0);
    pad = 8'h00;
    ticks(5);
    chk("e_fall_irq", {31'h0, irq}, 32'h0);
    bus(8'h18, 1'b0, 32'h0, "e_ip_rd", rd);
    chk("e_fall_ip0", {31'h0, rd[0]}, 32'h0);

    // Level interrupt on pin1.
    bus(8'h1C, 1'b1, 32'h00, "l_itype", rd);
    bus(8'h20, 1'b1, 32'h02, "l_ipol", rd);
    bus(8'h14, 1'b1, 32'h02, "l_ie", rd);
    pad = 8'h02;
    ticks(3);
    chk("l_irq", {31'h0, irq}, 32'h1);
    bus(8'h18, 1'b1, 32'h02, "l_w1c", rd);
    bus(8'h18, 1'b0, 32'h0, "l_ip_rd", rd);
    chk("l_ip1_reset", {31'h0, rd[1]}, 32'h1);
    pad = 8'h00;
    ticks(3);
    bus(8'h18, 1'b1, 32'h02, "l_w1c2", rd);
    bus(8'h18, 1'b0, 32'h0, "l_ip_rd2", rd);
    chk("l_ip1_clear", {31'h0, rd[1]}, 32'h0);

    // Both-edge event on pin2 coinciding with a W1C of the same bit.
    bus(8'h1C, 1'b1, 32'h04, "c_itype", rd);
    bus(8'h24, 1'b1, 32'h04, "c_iboth", rd);
    bus(8'h18, 1'b1, 32'h04, "c_pre", rd);
    pad = 8'h04;
    ticks(2);
    bus(8'h18, 1'b1, 32'h04, "c_w1c", rd);
    bus(8'h18, 1'b0, 32'h0, "c_ip_rd", rd);
    chk("c_ip2_wins", {31'h0, rd[2]}, 32'h1);

    // Randomised traffic and pad activity against the model.
    for (int n = 0; n < 150; n++) begin
      logic [7:0] a;
      logic       we;
      pad = 8'($urandom);
      a   = addrs[$urandom_range(0, 13)];
      we  = ($urandom_range(0, 1) == 1) && (a != 8'h28);
      if ($urandom_range(0, 7) == 0) begin
        breq.addr = {24'h0, a}; breq.w_data = $urandom; breq.w_en = we; breq.req = 1'b1; sel = 1'b0;
        tick();
        chk("r_nosel_ack", {31'h0, bresp.ack}, 32'h0);
        breq.req = 1'b0; breq.w_en = 1'b0; sel = 1'b1;
      end else begin
        bus(a, we, $urandom, $sformatf("r_%0d_%0h", n, a), rd);
      end
      chk("r_out", {24'h0, gout}, {24'h0, m_dout});
      chk("r_oe", {24'h0, goe}, {24'h0, m_dir});
      chk("r_irq", {31'h0, irq}, {31'h0, |(m_ip & m_ie)});
    end

`ifdef GPIO_DEBOUNCE_EN
    pad = 8'h00;
    bus(8'h14, 1'b1, 32'h00, "d_ie", rd);
    ticks(4);
    bus_x(8'h28, 1'b1, 32'h01, 32'h0, "d_dben", rd);
    pad = 8'h01; ticks(10); pad = 8'h00; ticks(25);
    bus_x(8'h0C, 1'b0, 32'h0, 32'h0, "d_glitch", rd);
    pad = 8'h01; ticks(17);
    bus_x(8'h0C, 1'b0, 32'h0, 32'h0, "d_before", rd);
    bus_x(8'h0C, 1'b0, 32'h0, 32'h1, "d_after", rd);
    pad = 8'h00; ticks(25);
    bus_x(8'h0C, 1'b0, 32'h0, 32'h0, "d_release", rd);
    bus_x(8'h28, 1'b1, 32'h00, 32'h0, "d_dben_off", rd);
`endif

    // Asynchronous reset in the middle of a read access.
    pad = 8'h00;
    bus(8'h00, 1'b1, 32'h5A, "a_dout", rd);
    breq.addr = 32'h0; breq.w_en = 1'b0; breq.req = 1'b1; sel = 1'b1;
    tick();
    chk("a_ack_up", {31'h0, bresp.ack}, 32'h1);
    chk("a_rdata_up", bresp.r_data, 32'h5A);
    #2 rst_n = 1'b0;
    #1;
    chk("a_ack_drop", {31'h0, bresp.ack}, 32'h0);
    chk("a_rdata_drop", bresp.r_data, 32'h0);
    chk("a_out_drop", {24'h0, gout}, 32'h0);
    breq.req = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
    bus(8'h00, 1'b0, 32'h0, "a_dout_rd", rd);
    bus(8'h10, 1'b0, 32'h0, "a_dir_rd", rd);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/gpio_ctrl_param.md
Name: gpio_ctrl_param

Overview:
Parametrised next-generation GPIO controller on the data bus, selected by the bus decoder through gpio_sel_i.
- NUM_PINS generic width.
- Split pad interface (out/oe/in) instead of an inout net.
- Two-flop input synchronisation.
- Atomic set/clear of output data.
- Per-pin level/edge/both-edge interrupts with write-1-to-clear pending bits.
- One aggregated irq_o to the platform interrupt controller.

Parameters:
NUM_PINS, 8, number of GPIO pins (1..32).
SYNC_STAGES, 2, input synchroniser depth (>=2).
DEBOUNCE_CYCLES, 16, stable-cycle count; used only when GPIO_DEBOUNCE_EN is defined.

Ports:
clk  input  1  system clock.
rst_n  input  1  asynchronous active-low reset.
gpio_sel_i  input  1  peripheral select from bus decoder.
dbus2gpio_i  input  type_dbus2peri_s  bus request (addr, w_data, w_en, req).
gpio2dbus_o  output  type_peri2dbus_s  bus response (r_data, ack).
gpio_in_i  input  NUM_PINS  raw pad inputs (asynchronous).
gpio_out_o  output  NUM_PINS  pad output value.
gpio_oe_o  output  NUM_PINS  pad output enable (1 = drive).
irq_o  output  1  OR of (IP & IE).

Behaviour:
- Reset is async, active-low. All registers clear to 0: gpio_out_o=0, gpio_oe_o=0 (all inputs), irq_o=0, ack=0, r_data=0. Synchroniser flops also clear to 0.
- Register map (word offsets, addr[7:0]). Bits above NUM_PINS read 0 and ignore writes.
  - 0x00 DOUT rw
  - 0x04 DSET wo: 1 sets the DOUT bit
  - 0x08 DCLR wo: 1 clears the DOUT bit
  - 0x0C DIN ro: synchronised input
  - 0x10 DIR rw: 1 = output
  - 0x14 IE rw
  - 0x18 IP: read; write-1-to-clear
  - 0x1C ITYPE rw: 0 = level, 1 = edge
  - 0x20 IPOL rw: 1 = high/rising, 0 = low/falling
  - 0x24 IBOTH rw: 1 = both edges, overrides IPOL in edge mode
  - Unmapped reads return 0; unmapped writes are ignored, still acked.
- gpio_out_o = DOUT; gpio_oe_o = DIR. DOUT holds its value regardless of DIR.
- DIN: SYNC_STAGES flop chain per pin, plus one extra "prev" flop for edge detection. DIN reflects the pad for every pin, including output pins (readback).
- Bus handshake:
  - A transaction is (req & gpio_sel_i) while ack_ff==0.
  - ack pulses high for exactly one cycle, the cycle after the request.
  - A request held across that ack cycle is not re-served. A new transaction is accepted at the earliest on the cycle after ack drops.
  - Write takes effect at the same edge that raises ack.
  - r_data is registered with ack and is 0 for writes.
- Interrupt pending, per pin, each cycle:
  - Level mode: IP bit set while DIN == IPOL. A W1C while the condition persists re-sets the bit on the next cycle.
  - Edge mode: IP bit set on a DIN transition matching IPOL/IBOTH.
  - Simultaneous set event and W1C: the set wins.
- IP updates regardless of IE; IE gates only irq_o.
- irq_o = |(IP_ff & IE_ff), derived only from flops.
- Latency with SYNC_STAGES=2: pad change before edge0 -> DIN valid after edge1 -> IP/irq_o high after edge2.
- Changing ITYPE/IPOL does not clear IP; software clears IP after reconfiguration.
- DSET and DCLR act on the current DOUT. Only one write per transaction, so no same-cycle conflict.
- Reset asserted mid-transaction: ack and r_data drop immediately; the transaction is lost.

Optional Feature:
GPIO_DEBOUNCE_EN.
- Defined: per-pin counter after the synchroniser. DIN updates only after the synchronised value differs from DIN for DEBOUNCE_CYCLES consecutive cycles. The counter resets on any bounce. Latency grows by DEBOUNCE_CYCLES. Adds a DBEN register at 0x28 (rw, per-pin enable); pins with DBEN=0 bypass the debouncer.
- Undefined: no counters, no DBEN (0x28 reads 0), latency as above.

Decomposition:
- Shared package gpio_pkg:
  - type_gpio_ctrl_regs_e register offset enum.
  - GPIO_MAX_PINS constant.
  - Reset-value constants.
  - Reuses type_dbus2peri_s/type_peri2dbus_s from the bus package.
- Sub-module gpio_in_cond, one per pin via generate: synchroniser, optional debouncer, prev flop, rise/fall outputs.

Test Plan:
- Reset: after reset release, read all registers -> 0, gpio_oe_o=0, irq_o=0; each access gives a single-cycle ack.
- Output path:
  - Write DIR=0xFF, DOUT=0xA5 -> gpio_out_o=0xA5.
  - DSET 0x0A -> 0xAF.
  - DCLR 0x81 -> 0x2E.
  - Read DIN with the pads looped back -> 0x2E.
- Edge interrupt: ITYPE=0x01, IPOL=0x01, IE=0x01; raise gpio_in_i[0] -> irq_o high 2 cycles later.
  - W1C IP=0x01 -> irq_o low.
  - A falling edge causes no interrupt.
- Level interrupt: ITYPE=0, IPOL=0x02, IE=0x02, hold pin1 high; W1C -> IP[1] reads 1 again next access.
  - Drop the pin, then W1C -> IP reads 0.
- Collision: IBOTH=0x04 with a pin2 edge landing on the same cycle as a W1C of bit 2 -> IP[2]=1.
- Debounce (macro defined, DEBOUNCE_CYCLES=16, DBEN=0x01): a 10-cycle glitch on pin0 -> no DIN change.
  - 20-cycle pulse -> DIN[0] toggles 16 cycles after the synchroniser.
  - Async reset mid-access -> ack=0 immediately.
